// File: rtl/ad9361_pkg.sv
// Shared definitions for the AD9361 receive-side stream framer.
package ad9361_pkg;

   // Header field positions inside the 64-bit header beat.
   localparam int unsigned MAGIC_LSB = 48;
   localparam int unsigned SEQ_LSB   = 32;
   localparam int unsigned TS_LSB    = 0;

   localparam logic [15:0] DEFAULT_HEADER_MAGIC = 16'hA55A;

   // Framer states.
   typedef logic [1:0] state_t;
   localparam state_t StIdle    = 2'd0;
   localparam state_t StHeader  = 2'd1;
   localparam state_t StPayload = 2'd2;

   function automatic logic [63:0] make_header(input logic [15:0] magic,
                                               input logic [15:0] seq,
                                               input logic [31:0] ts);
      logic [63:0] hdr;
      hdr                   = '0;
      hdr[MAGIC_LSB +: 16]  = magic;
      hdr[SEQ_LSB +: 16]    = seq;
      hdr[TS_LSB +: 32]     = ts;
      return hdr;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer. Outputs come straight from flops; the
// input ready is a flop meaning "not full".
module axis_skid_buffer #(
   parameter int unsigned WIDTH = 65
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             in_ready_q;
   logic             push, pop;

   assign push = in_valid_i && in_ready_q;
   assign pop  = out_valid_q && out_ready_i;

   // Pop refills the output slot from the skid slot first, so order is kept.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (pop) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b0;
         end
      end
      if (push) begin
         if (!out_valid_d) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
         end
      end
   end

   // Storage and registered ready.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= !skid_valid_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: rtl/ad9361_axis_framer.sv
// Frames the 64-bit AD9361 sample stream into fixed-length packets: one
// header beat {magic, seq, timestamp} followed by PACKET_LENGTH payload beats.
module ad9361_axis_framer
   import ad9361_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned PACKET_LENGTH = 256,
   parameter logic [15:0] HEADER_MAGIC  = DEFAULT_HEADER_MAGIC
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [15:0]           seq_num,
   output logic                  pkt_active
);

   localparam logic [15:0] LAST_BEAT = 16'(PACKET_LENGTH - 1);

   state_t                state_q, state_d;
   logic [31:0]           ts_q;
   logic [31:0]           ts_latch_q, ts_latch_d;
   logic [15:0]           seq_q, seq_d;
   logic [15:0]           beat_q, beat_d;
   logic                  skid_in_valid, skid_in_ready, skid_in_last;
   logic [DATA_WIDTH-1:0] skid_in_data;
   logic                  s_hs;

   assign s_hs = (state_q == StPayload) && s_axis_tvalid && skid_in_ready;

   // Free-running capture timestamp.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + 32'd1;
      end
   end

   // Select what is offered to the skid buffer; input is only accepted in PAYLOAD.
   always_comb begin
      skid_in_valid = 1'b0;
      skid_in_data  = '0;
      skid_in_last  = 1'b0;
      s_axis_tready = 1'b0;
      case (state_q)
         StHeader: begin
            skid_in_valid = 1'b1;
            skid_in_data  = make_header(HEADER_MAGIC, seq_q, ts_latch_q);
         end
         StPayload: begin
            s_axis_tready = skid_in_ready;
            skid_in_valid = s_axis_tvalid;
            skid_in_data  = s_axis_tdata;
            skid_in_last  = (beat_q == LAST_BEAT);
         end
         default: ;
      endcase
   end

   // Packet state machine; enable only matters when deciding to start.
   always_comb begin
      state_d    = state_q;
      ts_latch_d = ts_latch_q;
      seq_d      = seq_q;
      beat_d     = beat_q;
      case (state_q)
         StIdle: begin
            if (enable && s_axis_tvalid) begin
               ts_latch_d = ts_q;
               state_d    = StHeader;
            end
         end
         StHeader: begin
            if (skid_in_ready) begin
               beat_d  = '0;
               state_d = StPayload;
            end
         end
         StPayload: begin
            if (s_hs) begin
               beat_d = beat_q + 16'd1;
               if (beat_q == LAST_BEAT) begin
                  seq_d   = seq_q + 16'd1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Framer state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         ts_latch_q <= '0;
         seq_q      <= '0;
         beat_q     <= '0;
      end else begin
         state_q    <= state_d;
         ts_latch_q <= ts_latch_d;
         seq_q      <= seq_d;
         beat_q     <= beat_d;
      end
   end

   axis_skid_buffer #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_skid (
      .clk_i       (clk),
      .rst_ni      (resetn),
      .in_valid_i  (skid_in_valid),
      .in_ready_o  (skid_in_ready),
      .in_data_i   ({skid_in_last, skid_in_data}),
      .out_valid_o (m_axis_tvalid),
      .out_ready_i (m_axis_tready),
      .out_data_o  ({m_axis_tlast, m_axis_tdata})
   );

   assign seq_num    = seq_q;
   assign pkt_active = (state_q != StIdle);

endmodule

// File: tb/tb_ad9361_axis_framer.sv
// Randomized bench for ad9361_axis_framer with a packet-level reference model.
module tb_ad9361_axis_framer;

   localparam int unsigned L     = 4;
   localparam logic [15:0] MAGIC = 16'hA55A;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [63:0] s_axis_tdata = '0;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic [63:0] m_axis_tdata;
   logic [15:0] seq_num;
   logic        pkt_active;

   ad9361_axis_framer #(
      .DATA_WIDTH    (64),
      .PACKET_LENGTH (L),
      .HEADER_MAGIC  (MAGIC)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .enable        (enable),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .seq_num       (seq_num),
      .pkt_active    (pkt_active)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_miss = 0;
   int unsigned cyc;
   bit          en;
   int          rdy_pct;
   logic [63:0] src_q[$];
   logic [64:0] exp_q[$];
   logic [64:0] obs_q[$];
   bit          mdl_idle;
   logic [15:0] mdl_seq;
   int          mdl_cnt;
   int          s_hs_cnt;
   int          stall_viol;
   int          acc_viol;
   bit          prev_stall;
   logic [64:0] prev_beat;
   int          first_mv;

   task automatic clear_model();
      cyc = 0; mdl_idle = 1'b1; mdl_seq = '0; mdl_cnt = 0;
      exp_q.delete(); obs_q.delete();
      s_hs_cnt = 0; stall_viol = 0; acc_viol = 0; prev_stall = 1'b0; first_mv = -1;
   endtask

   task automatic do_reset();
      resetn = 1'b0; en = 1'b0; rdy_pct = 100; src_q.delete();
      enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      clear_model();
   endtask

   // One clock: drive inputs, advance the model, record handshakes due at the next edge.
   task automatic cycle();
      s_axis_tvalid = (src_q.size() != 0);
      s_axis_tdata  = (src_q.size() != 0) ? src_q[0] : 64'd0;
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      enable        = en;
      #1;
      if (first_mv < 0 && m_axis_tvalid) first_mv = int'(cyc);
      if (prev_stall && (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev_beat))
         stall_viol++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
      if (mdl_idle && en && s_axis_tvalid) begin
         exp_q.push_back({1'b0, MAGIC, mdl_seq, cyc});
         mdl_idle = 1'b0;
         mdl_cnt  = 0;
      end
      if (s_axis_tvalid && s_axis_tready) begin
         if (mdl_idle) acc_viol++;
         mdl_cnt++;
         exp_q.push_back({(mdl_cnt == L), src_q[0]});
         void'(src_q.pop_front());
         s_hs_cnt++;
         if (mdl_cnt == L) begin
            mdl_seq  = mdl_seq + 16'd1;
            mdl_idle = 1'b1;
         end
      end
      if (m_axis_tvalid && m_axis_tready) obs_q.push_back({m_axis_tlast, m_axis_tdata});
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_until_obs(input int n, input int bound, output bit timed_out);
      int k;
      k = 0;
      while (obs_q.size() < n && k < bound) begin
         cycle();
         k++;
      end
      timed_out = (obs_q.size() < n);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #2;
      n_vec++; if (m_axis_tvalid !== 1'b0) begin n_miss++; $display("FAIL rst_mvalid got %b want 0", m_axis_tvalid); end
      n_vec++; if (m_axis_tlast !== 1'b0) begin n_miss++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
      n_vec++; if (m_axis_tdata !== 64'd0) begin n_miss++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
      n_vec++; if (s_axis_tready !== 1'b0) begin n_miss++; $display("FAIL rst_sready got %b want 0", s_axis_tready); end
      n_vec++; if (seq_num !== 16'd0) begin n_miss++; $display("FAIL rst_seq got %h want 0", seq_num); end
      n_vec++; if (pkt_active !== 1'b0) begin n_miss++; $display("FAIL rst_active got %b want 0", pkt_active); end
   endtask

   task automatic test_basic();
      logic [64:0] want [5];
      bit to;
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= 4; i++) src_q.push_back(64'(i));
      want[0] = {1'b0, 64'hA55A_0000_0000_0000};
      want[1] = {1'b0, 64'd1}; want[2] = {1'b0, 64'd2};
      want[3] = {1'b0, 64'd3}; want[4] = {1'b1, 64'd4};
      run_until_obs(5, 50, to);
      repeat (3) cycle();
      n_vec++; if (obs_q.size() != 5) begin n_miss++; $display("FAIL basic_count got %0d want 5", obs_q.size()); end
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         n_vec++;
         if (obs_q[i] !== want[i]) begin n_miss++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], want[i]); end
      end
      n_vec++; if (seq_num !== 16'd1) begin n_miss++; $display("FAIL basic_seq got %h want 1", seq_num); end
      n_vec++; if (pkt_active !== 1'b0) begin n_miss++; $display("FAIL basic_active got %b want 0", pkt_active); end
   endtask

   task automatic test_timestamp();
      bit to;
      do_reset();
      en = 1'b1;
      repeat (10) cycle();
      for (int i = 0; i < 4; i++) src_q.push_back({$urandom, $urandom});
      run_until_obs(5, 50, to);
      n_vec++; if (to) begin n_miss++; $display("FAIL ts_timeout got %0d beats want 5", obs_q.size()); end
      n_vec++; if (first_mv != 12) begin n_miss++; $display("FAIL ts_valid_cycle got %0d want 12", first_mv); end
      if (obs_q.size() > 0) begin
         n_vec++; if (obs_q[0][31:0] !== 32'd10) begin n_miss++; $display("FAIL ts_value got %0d want 10", obs_q[0][31:0]); end
         n_vec++; if (obs_q[0][63:48] !== MAGIC) begin n_miss++; $display("FAIL ts_magic got %h want %h", obs_q[0][63:48], MAGIC); end
      end
   endtask

   task automatic test_backpressure();
      bit to;
      do_reset();
      en = 1'b1; rdy_pct = 50;
      for (int i = 0; i < 100 * L; i++) src_q.push_back({$urandom, $urandom});
      run_until_obs(100 * (L + 1), 20000, to);
      repeat (5) cycle();
      n_vec++; if (obs_q.size() != exp_q.size() || to) begin n_miss++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      n_vec++; if (stall_viol != 0) begin n_miss++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_viol); end
      n_vec++; if (acc_viol != 0) begin n_miss++; $display("FAIL bp_accept_idle got %0d want 0", acc_viol); end
      n_vec++; if (seq_num !== 16'd100) begin n_miss++; $display("FAIL bp_seq got %0d want 100", seq_num); end
   endtask

   task automatic test_enable_drop();
      int k;
      int lasts;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 8; i++) src_q.push_back({$urandom, $urandom});
      k = 0;
      while (s_hs_cnt < 2 && k < 100) begin cycle(); k++; end
      en = 1'b0;
      repeat (30) cycle();
      lasts = 0;
      foreach (obs_q[i]) if (obs_q[i][64]) lasts++;
      n_vec++; if (obs_q.size() != 5) begin n_miss++; $display("FAIL en_count got %0d want 5", obs_q.size()); end
      n_vec++; if (lasts != 1) begin n_miss++; $display("FAIL en_tlast_count got %0d want 1", lasts); end
      if (obs_q.size() == 5) begin
         n_vec++; if (obs_q[4][64] !== 1'b1) begin n_miss++; $display("FAIL en_tlast_pos got %b want 1", obs_q[4][64]); end
         for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL en_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
         end
      end
      n_vec++; if (src_q.size() != 4) begin n_miss++; $display("FAIL en_left got %0d want 4", src_q.size()); end
      n_vec++; if (seq_num !== 16'd1) begin n_miss++; $display("FAIL en_seq got %h want 1", seq_num); end
   endtask

   task automatic test_seq_wrap();
      bit to;
      do_reset();
      repeat (2) cycle();
      force dut.seq_q = 16'hFFFF;
      cycle();
      release dut.seq_q;
      mdl_seq = 16'hFFFF;
      en = 1'b1;
      for (int i = 0; i < 2 * L; i++) src_q.push_back({$urandom, $urandom});
      run_until_obs(2 * (L + 1), 100, to);
      n_vec++; if (to) begin n_miss++; $display("FAIL wrap_timeout got %0d beats want 10", obs_q.size()); end
      if (!to) begin
         n_vec++; if (obs_q[0][47:32] !== 16'hFFFF) begin n_miss++; $display("FAIL wrap_seq0 got %h want ffff", obs_q[0][47:32]); end
         n_vec++; if (obs_q[5][47:32] !== 16'h0000) begin n_miss++; $display("FAIL wrap_seq1 got %h want 0000", obs_q[5][47:32]); end
         for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL wrap_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
         end
      end
      n_vec++; if (seq_num !== 16'd1) begin n_miss++; $display("FAIL wrap_seqnum got %h want 1", seq_num); end
   endtask

   task automatic test_reset_mid();
      int k;
      bit to;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < L; i++) src_q.push_back({$urandom, $urandom});
      k = 0;
      while (s_hs_cnt < 2 && k < 100) begin cycle(); k++; end
      #2;
      resetn = 1'b0;
      #1;
      n_vec++; if (m_axis_tvalid !== 1'b0) begin n_miss++; $display("FAIL mid_mvalid got %b want 0", m_axis_tvalid); end
      n_vec++; if (m_axis_tdata !== 64'd0) begin n_miss++; $display("FAIL mid_tdata got %h want 0", m_axis_tdata); end
      n_vec++; if (m_axis_tlast !== 1'b0) begin n_miss++; $display("FAIL mid_tlast got %b want 0", m_axis_tlast); end
      n_vec++; if (s_axis_tready !== 1'b0) begin n_miss++; $display("FAIL mid_sready got %b want 0", s_axis_tready); end
      n_vec++; if (pkt_active !== 1'b0) begin n_miss++; $display("FAIL mid_active got %b want 0", pkt_active); end
      @(negedge clk);
      resetn = 1'b1;
      clear_model();
      src_q.delete();
      for (int i = 0; i < L; i++) src_q.push_back({$urandom, $urandom});
      run_until_obs(L + 1, 50, to);
      n_vec++; if (to) begin n_miss++; $display("FAIL mid_timeout got %0d beats want 5", obs_q.size()); end
      if (!to) begin
         n_vec++; if (obs_q[0][47:32] !== 16'h0000) begin n_miss++; $display("FAIL mid_hdr_seq got %h want 0000", obs_q[0][47:32]); end
         for (int i = 0; i < L + 1; i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL mid_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 3 * L; i++) src_q.push_back({$urandom, $urandom});
      run_until_obs(3 * (L + 1), 100, to);
      n_vec++; if (to) begin n_miss++; $display("FAIL b2b_timeout got %0d beats want 15", obs_q.size()); end
      if (!to) begin
         for (int i = 0; i < 3 * (L + 1); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL b2b_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
         end
         // Each packet spans one IDLE, one HEADER and L payload cycles at full rate.
         for (int p = 1; p < 3; p++) begin
            n_vec++;
            if (obs_q[p*(L+1)][31:0] - obs_q[(p-1)*(L+1)][31:0] !== 32'(L + 2)) begin
               n_miss++;
               $display("FAIL b2b_gap%0d got %0d want %0d", p,
                        obs_q[p*(L+1)][31:0] - obs_q[(p-1)*(L+1)][31:0], L + 2);
            end
            n_vec++;
            if (obs_q[p*(L+1)][47:32] !== 16'(p)) begin
               n_miss++;
               $display("FAIL b2b_seq%0d got %h want %h", p, obs_q[p*(L+1)][47:32], 16'(p));
            end
         end
      end
   endtask

   initial begin
      clear_model();
      en = 1'b0;
      rdy_pct = 100;
      test_reset();
      test_basic();
      test_timestamp();
      test_backpressure();
      test_enable_drop();
      test_seq_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
